cobra_run_ctrl: RTL

- Run-control sequencer for the CYBERcobra core: decides, cycle by cycle, whether the core may advance (execute one instruction, update PC and register file).
- Supports free run, single step, halt, a PC breakpoint and an instruction-count limit.
- Button inputs come from board switches/buttons; the core's PC is fed back in.
- core_en_o drives the core's PC-update and register-file write enables.

---
 rtl/cobra_run_ctrl.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/cobra_run_ctrl.sv
// Run-control sequencer for the CYBERcobra core: free run, single step, halt,
// PC breakpoint and instruction-count limit gating the core's execute enable.
module cobra_run_ctrl #(
    parameter int PC_W  = 32,
    parameter int CNT_W = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             run_i,
    input  logic             step_i,
    input  logic             halt_i,
    input  logic             bp_en_i,
    input  logic [PC_W-1:0]  bp_addr_i,
    input  logic [PC_W-1:0]  pc_i,
    input  logic [CNT_W-1:0] max_cnt_i,
    output logic             core_en_o,
    output logic [1:0]       state_o,
    output logic [CNT_W-1:0] instr_cnt_o,
    output logic             bp_hit_o,
    output logic             limit_o
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        STEP  = 2'd2,
        BREAK = 2'd3
    } state_t;

    state_t           state, state_nxt;
    logic             run_prev, step_prev, halt_prev;
    logic             halt_ev, step_ev, run_ev;
    logic             ret_brk, ret_brk_nxt;
    logic             skip_bp, skip_bp_nxt;
    logic             bp_match, cnt_clr, limit_set, bp_entry;
    logic [CNT_W-1:0] cnt_inc;

    // Events resolved by priority: a halt masks step and run, a step masks run.
    assign halt_ev = halt_i & ~halt_prev;
    assign step_ev = step_i & ~step_prev & ~halt_ev;
    assign run_ev  = run_i & ~run_prev & ~halt_ev & ~step_ev;

    assign bp_match = bp_en_i & (pc_i == bp_addr_i) & ~skip_bp;
    assign cnt_inc  = (&instr_cnt_o) ? instr_cnt_o : instr_cnt_o + CNT_W'(1);
    assign state_o  = state;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        core_en_o   = 1'b0;
        ret_brk_nxt = ret_brk;
        skip_bp_nxt = skip_bp;
        cnt_clr     = 1'b0;
        limit_set   = 1'b0;
        bp_entry    = 1'b0;
        case (state)
            IDLE: begin
                if (run_ev) begin
                    state_nxt = RUN;
                    cnt_clr   = 1'b1;
                end else if (step_ev) begin
                    state_nxt   = STEP;
                    ret_brk_nxt = 1'b0;
                end
            end
            RUN: begin
                if (halt_ev) begin
                    state_nxt = IDLE;
                end else if (bp_match) begin
                    state_nxt = BREAK;
                    bp_entry  = 1'b1;
                end else begin
                    core_en_o = 1'b1;
                    if ((max_cnt_i != '0) && (cnt_inc == max_cnt_i)) begin
                        state_nxt = IDLE;
                        limit_set = 1'b1;
                    end
                end
            end
            STEP: begin
                core_en_o = 1'b1;
                state_nxt = ret_brk ? BREAK : IDLE;
            end
            BREAK: begin
                if (halt_ev) begin
                    state_nxt = IDLE;
                end else if (step_ev) begin
                    state_nxt   = STEP;
                    ret_brk_nxt = 1'b1;
                end else if (run_ev) begin
                    state_nxt   = RUN;
                    skip_bp_nxt = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
        // The breakpoint re-arms once the skipped instruction has executed.
        if (core_en_o || (state_nxt == IDLE)) begin
            skip_bp_nxt = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            run_prev    <= 1'b0;
            step_prev   <= 1'b0;
            halt_prev   <= 1'b0;
            ret_brk     <= 1'b0;
            skip_bp     <= 1'b0;
            bp_hit_o    <= 1'b0;
            instr_cnt_o <= '0;
            limit_o     <= 1'b0;
        end else begin
            run_prev  <= run_i;
            step_prev <= step_i;
            halt_prev <= halt_i;
            ret_brk   <= ret_brk_nxt;
            skip_bp   <= skip_bp_nxt;
            bp_hit_o  <= bp_entry;
            if (cnt_clr) begin
                instr_cnt_o <= '0;
            end else if (core_en_o) begin
                instr_cnt_o <= cnt_inc;
            end
            if (cnt_clr) begin
                limit_o <= 1'b0;
            end else if (limit_set) begin
                limit_o <= 1'b1;
            end
        end
    end

endmodule
